// File: rtl/vram_write_arbiter.sv
// Round-robin arbiter sharing the VRAM write port between N_REQ valid/ready requesters.
// Define VRAM_FILL_EN to add the whole-memory fill engine (one word per cycle).
module vram_write_arbiter #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_address,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_din,
  input  logic                        fill_start,
  input  logic [DATA_WIDTH-1:0]       fill_color,
  output logic                        fill_busy,
  output logic                        fill_done,
  output logic signed [31:0]          data_address,
  output logic [DATA_WIDTH-1:0]       data_din,
  output logic                        data_we
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(N_REQ - 1);

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;

  logic                  arb_en;
  logic                  grant_any;
  logic [PTR_W-1:0]      grant_idx;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0] grant_din;
  logic [N_REQ-1:0]      grant;

`ifdef VRAM_FILL_EN
  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] color_q, color_d;
  logic                  done_q, done_d;

  // A fill request takes the cycle it arrives in, so no requester is granted alongside it.
  assign arb_en    = reset_n && (state_q == ST_ARB) && !fill_start;
  assign fill_busy = (state_q == ST_FILL);
  assign fill_done = done_q;
`else
  logic unused_fill;

  assign arb_en      = reset_n;
  assign fill_busy   = 1'b0;
  assign fill_done   = 1'b0;
  assign unused_fill = ^{fill_start, fill_color};
`endif

  // Rotated search ptr+1 .. N_REQ-1, then 0 .. ptr, done as two ascending passes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant      = '0;
    grant_any  = 1'b0;
    grant_idx  = ptr_q;
    grant_addr = '0;
    grant_din  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_en && !grant_any && req_valid[i] && (i > int'(ptr_q))) begin
        grant_any  = 1'b1;
        grant_idx  = PTR_W'(i);
        grant[i]   = 1'b1;
        grant_addr = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        grant_din  = req_din[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_en && !grant_any && req_valid[i] && (i <= int'(ptr_q))) begin
        grant_any  = 1'b1;
        grant_idx  = PTR_W'(i);
        grant[i]   = 1'b1;
        grant_addr = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        grant_din  = req_din[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign req_ready = grant;

  always_comb begin
    ptr_d  = grant_any ? grant_idx : ptr_q;
    we_d   = grant_any;
    addr_d = grant_any ? grant_addr : addr_q;
    din_d  = grant_any ? grant_din  : din_q;
`ifdef VRAM_FILL_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    done_d  = 1'b0;
    if (state_q == ST_FILL) begin
      we_d   = 1'b1;
      addr_d = cnt_q;
      din_d  = color_q;
      if (cnt_q == '1) begin
        state_d = ST_ARB;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
      end
    end else if (fill_start) begin
      state_d = ST_FILL;
      cnt_d   = '0;
      color_d = fill_color;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= PTR_RESET;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
`ifdef VRAM_FILL_EN
      state_q <= ST_ARB;
      cnt_q   <= '0;
      color_q <= '0;
      done_q  <= 1'b0;
`endif
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
`ifdef VRAM_FILL_EN
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      done_q  <= done_d;
`endif
    end
  end

  assign data_we      = we_q;
  assign data_din     = din_q;
  assign data_address = $signed({{(32-ADDR_WIDTH){1'b0}}, addr_q});

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter: a transaction-level model checked every cycle, plus directed
// literal expectations. Fill scenarios run when VRAM_FILL_EN is defined.
module tb_vram_write_arbiter;

  localparam int N_REQ = 2;
  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;
`ifdef VRAM_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*AW-1:0]  req_address;
  logic [N_REQ*DW-1:0]  req_din;
  logic                 fill_start;
  logic [DW-1:0]        fill_color;
  logic                 fill_busy;
  logic                 fill_done;
  logic signed [31:0]   data_address;
  logic [DW-1:0]        data_din;
  logic                 data_we;

  vram_write_arbiter #(.N_REQ(N_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_address  (req_address),
    .req_din      (req_din),
    .fill_start   (fill_start),
    .fill_color   (fill_color),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done),
    .data_address (data_address),
    .data_din     (data_din),
    .data_we      (data_we)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Model: last granted index, the write expected on the port, and the fill progress.
  int            m_last;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  bit            m_fill;
  int            m_next;
  logic [DW-1:0] m_color;
  bit            m_done;

  function automatic int pick(input logic [N_REQ-1:0] v, input int last, input bit blocked);
    if (blocked) return -1;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx = (last + k) % N_REQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_last  <= N_REQ - 1;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_din   <= '0;
      m_fill  <= 1'b0;
      m_next  <= 0;
      m_color <= '0;
      m_done  <= 1'b0;
    end else if (m_fill) begin
      m_we   <= 1'b1;
      m_addr <= AW'(m_next);
      m_din  <= m_color;
      m_done <= (m_next == DEPTH - 1);
      if (m_next == DEPTH - 1) m_fill <= 1'b0;
      else m_next <= m_next + 1;
    end else begin
      m_done <= 1'b0;
      if (FILL_EN && fill_start) begin
        m_fill  <= 1'b1;
        m_next  <= 0;
        m_color <= fill_color;
        m_we    <= 1'b0;
      end else if (pick(req_valid, m_last, 1'b0) >= 0) begin
        m_we   <= 1'b1;
        m_last <= pick(req_valid, m_last, 1'b0);
        m_addr <= req_address[pick(req_valid, m_last, 1'b0)*AW +: AW];
        m_din  <= req_din[pick(req_valid, m_last, 1'b0)*DW +: DW];
      end else begin
        m_we <= 1'b0;
      end
    end
  end

  int exp_g;
  always @(negedge clk) begin
    exp_g = pick(req_valid, m_last, !reset_n || m_fill || (FILL_EN && fill_start));
    check("model_ready", 32'(req_ready), (exp_g < 0) ? 32'd0 : (32'd1 << exp_g));
    check("model_we",    32'(data_we),   32'(m_we));
    check("model_addr",  data_address,   32'(m_addr));
    check("model_din",   32'(data_din),  32'(m_din));
    check("model_busy",  32'(fill_busy), 32'(m_fill));
    check("model_done",  32'(fill_done), 32'(m_done));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_address[i*AW +: AW] = a;
    req_din[i*DW +: DW]     = d;
  endtask

  task automatic reset_pulse();
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

`ifdef VRAM_FILL_EN
  task automatic run_until_done(output int busy_n, output bit seen);
    busy_n = 0;
    seen   = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (fill_busy) busy_n++;
      if (fill_done) begin
        seen = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic wait_addr(input int a, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (data_we && data_address == a) begin
        seen = 1'b1;
        return;
      end
    end
  endtask
`endif

  initial begin
    reset_n     = 1'b0;
    req_valid   = 2'b11;
    req_address = '0;
    req_din     = '0;
    fill_start  = 1'b0;
    fill_color  = '0;

    // Reset holds everything quiet even with both requesters valid.
    repeat (3) begin
      @(negedge clk);
      check("rst_we",    32'(data_we),   32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_busy",  32'(fill_busy), 32'd0);
    end

    // Single writer: same-cycle ready, write on the port one cycle later.
    step();
    reset_n   = 1'b1;
    req_valid = 2'b01;
    set_req(0, 12'h123, 8'hE0);
    @(negedge clk);
    check("single_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    check("single_we",   32'(data_we),  32'd1);
    check("single_addr", data_address,  32'h123);
    check("single_din",  32'(data_din), 32'hE0);
    step();
    @(negedge clk);
    check("idle_we",   32'(data_we), 32'd0);
    check("idle_hold", data_address, 32'h123);

    // Contention after reset: grants alternate 0,1,0,1.
    reset_pulse();
    req_valid = 2'b11;
    set_req(0, 12'h010, 8'hA0);
    set_req(1, 12'h020, 8'h0B);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("rr_ready", 32'(req_ready), (j % 2 == 0) ? 32'h1 : 32'h2);
      if (j > 0) check("rr_addr", data_address, (j % 2 == 1) ? 32'h010 : 32'h020);
      step();
    end
    req_valid = 2'b00;
    @(negedge clk);
    check("rr_last_addr", data_address,  32'h020);
    check("rr_last_din",  32'(data_din), 32'h0B);

    // Pointer now at 1: lone requester 1 wins, then requester 0 is ahead of 1.
    step();
    req_valid = 2'b10;
    set_req(1, 12'hFFF, 8'h3C);
    step();
    req_valid = 2'b11;
    @(negedge clk);
    check("rr_after1", 32'(req_ready), 32'h1);
    check("max_addr",  data_address,   32'hFFF);
    step();
    req_valid = 2'b00;

`ifdef VRAM_FILL_EN
    begin
      int busy_n;
      bit seen;

      // Full fill with requester 0 waiting; it is granted in the fill_done cycle.
      step();
      fill_start = 1'b1;
      fill_color = 8'h1C;
      step();
      fill_start = 1'b0;
      req_valid  = 2'b01;
      set_req(0, 12'h3AB, 8'h77);
      run_until_done(busy_n, seen);
      if (!seen) fail("fill_done_wait");
      else begin
        check("fill_busy_cycles", 32'(busy_n), 32'd4096);
        check("fill_grant_done",  32'(req_ready), 32'h1);
        check("fill_last_addr",   data_address,   32'hFFF);
        check("fill_last_din",    32'(data_din),  32'h1C);
      end
      step();
      req_valid = 2'b00;
      @(negedge clk);
      check("fill_done_pulse", 32'(fill_done), 32'd0);
      check("post_fill_addr",  data_address,   32'h3AB);

      // Fill beats a simultaneous request; a second fill_start mid-fill is ignored.
      step();
      fill_start = 1'b1;
      fill_color = 8'h5A;
      req_valid  = 2'b10;
      set_req(1, 12'h456, 8'h99);
      @(negedge clk);
      check("collide_ready", 32'(req_ready), 32'h0);
      step();
      fill_start = 1'b0;
      wait_addr(100, seen);
      if (!seen) fail("cnt100_wait");
      step();
      fill_start = 1'b1;
      fill_color = 8'hFF;
      step();
      fill_start = 1'b0;
      run_until_done(busy_n, seen);
      if (!seen) fail("fill2_done_wait");
      else begin
        check("refill_ignored_din", 32'(data_din),  32'h5A);
        check("collide_grant",      32'(req_ready), 32'h2);
      end
      step();
      req_valid = 2'b00;

      // Reset in the middle of a fill aborts it at once.
      step();
      fill_start = 1'b1;
      fill_color = 8'h33;
      step();
      fill_start = 1'b0;
      wait_addr(2000, seen);
      if (!seen) fail("cnt2000_wait");
      #2;
      reset_n = 1'b0;
      #1;
      check("abort_we",   32'(data_we),   32'd0);
      check("abort_addr", data_address,   32'd0);
      check("abort_din",  32'(data_din),  32'd0);
      check("abort_busy", 32'(fill_busy), 32'd0);
      step();
      reset_n = 1'b1;
      repeat (5) begin
        @(negedge clk);
        check("abort_no_resume", 32'(data_we), 32'd0);
      end
    end
`else
    // Without the fill engine, fill_start is ignored and the request is served.
    step();
    fill_start = 1'b1;
    fill_color = 8'h55;
    req_valid  = 2'b01;
    set_req(0, 12'h777, 8'h12);
    @(negedge clk);
    check("nofill_ready", 32'(req_ready), 32'h1);
    step();
    fill_start = 1'b0;
    req_valid  = 2'b00;
    @(negedge clk);
    check("nofill_busy", 32'(fill_busy), 32'd0);
    check("nofill_addr", data_address,   32'h777);
    step();
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
